// File: rtl/clock_divider_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clock_divider_monitor_pkg
//   Shared definitions for the divided-clock monitor:
//     - FSM state encoding (IDLE / ARM / MEASURE), also visible on io_state
//     - default widths, tolerance and lost-clock timeout
//   CDM_TIMEOUT is also the value the clock_divider_sim instantiation helpers
//   use, so a monitor and its divider agree on what "lost clock" means.
// -----------------------------------------------------------------------------
package clock_divider_monitor_pkg;

  localparam int unsigned CDM_DIV_W   = 8;
  localparam int unsigned CDM_CNT_W   = 16;
  localparam int unsigned CDM_TOL     = 1;
  localparam int unsigned CDM_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } cdm_state_e;

endpackage

// File: rtl/clock_divider_monitor_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//   Three-flop synchronizer for an asynchronous level input, with a rising
//   edge detector on the synchronized level. Usable for any async level.
//
//   Ports:
//     clk_i    sampling clock
//     rst_ni   asynchronous active-low reset
//     async_i  asynchronous level input
//     level_o  synchronized level (second flop)
//     rise_o   one-cycle pulse on a synchronized 0->1 transition
//
//   Latency: async_i first sampled high at edge N -> rise_o high during the
//   cycle after edge N+1.
// -----------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s3 only delays s2 for the edge detector; it never feeds level_o.
  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/clock_divider_monitor.sv
// -----------------------------------------------------------------------------
// clock_divider_monitor
//   Samples a divided clock as asynchronous data in the reference clock domain,
//   measures its period and high time in reference cycles, flags a period that
//   differs from io_div by more than TOL, and flags a lost clock.
//
//   Parameters:
//     DIV_W    width of io_div
//     CNT_W    width of the period/high counters and outputs (CNT_W >= DIV_W)
//     TOL      allowed |period - io_div| before io_err_period is raised
//     TIMEOUT  reference cycles without a rising edge before io_err_timeout;
//              must be < 2^CNT_W
//
//   Ports:
//     clock           reference clock
//     reset           asynchronous active-low reset
//     io_en           measurement enable; 0 forces IDLE on the next cycle
//     io_clear        synchronous clear of the sticky error flags
//     io_div          expected divide ratio (sampled at each rising edge)
//     io_clock_in     divided clock under test, asynchronous to clock
//     io_period       last measured period (reference cycles)
//     io_high         last measured high time (reference cycles)
//     io_valid        one-cycle pulse in the cycle io_period/io_high update;
//                     there is no back-pressure, a consumer must take it then
//     io_err_period   sticky period-mismatch flag
//     io_err_timeout  sticky lost-clock flag
//     io_state        FSM state (cdm_state_e), for debug
// -----------------------------------------------------------------------------
module clock_divider_monitor
  import clock_divider_monitor_pkg::*;
#(
  parameter int unsigned DIV_W   = CDM_DIV_W,
  parameter int unsigned CNT_W   = CDM_CNT_W,
  parameter int unsigned TOL     = CDM_TOL,
  parameter int unsigned TIMEOUT = CDM_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_clear,
  input  logic [DIV_W-1:0] io_div,
  input  logic             io_clock_in,
  output logic [CNT_W-1:0] io_period,
  output logic [CNT_W-1:0] io_high,
  output logic             io_valid,
  output logic             io_err_period,
  output logic             io_err_timeout,
  output logic [1:0]       io_state
);

  localparam int unsigned DW = CNT_W + 1;
  localparam logic [CNT_W:0]   TOL_V     = DW'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchronizer / edge detect
  // ---------------------------------------------------------------------------
  logic level;
  logic rise;

  sync_edge_detect u_sync (
    .clk_i   (clock),
    .rst_ni  (reset),
    .async_i (io_clock_in),
    .level_o (level),
    .rise_o  (rise)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  cdm_state_e       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] hcnt_q,   hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q,   high_d;
  logic             valid_q,  valid_d;
  logic             errp_q,   errp_d;
  logic             errt_q,   errt_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hcnt_inc;
  logic             timeout_hit;

  // Saturating increments: a stuck input must never wrap a counter back into
  // a plausible-looking period.
  assign cnt_inc     = (cnt_q  == '1) ? cnt_q  : cnt_q  + CNT_ONE;
  assign hcnt_inc    = (hcnt_q == '1) ? hcnt_q : hcnt_q + CNT_ONE;
  assign timeout_hit = (cnt_q == TIMEOUT_V);

  // Period check in CNT_W+1 signed bits so io_div > cnt goes negative cleanly.
  logic [CNT_W:0]        div_ext;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]        diff_mag;
  logic                  period_bad;

  assign div_ext    = DW'(io_div);
  assign diff       = $signed({1'b0, cnt_q}) - $signed(div_ext);
  assign diff_mag   = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign period_bad = (diff_mag > TOL_V);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic errp_new;
  logic errt_new;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    errp_new = 1'b0;
    errt_new = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        hcnt_d = '0;
        state_d = ST_ARM;
      end

      ST_ARM: begin
        cnt_d  = cnt_inc;
        hcnt_d = level ? hcnt_inc : hcnt_q;
        if (rise) begin
          // First edge only aligns the measurement; the partial period
          // before it is thrown away.
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
          state_d = ST_MEASURE;
        end else if (timeout_hit) begin
          errt_new = 1'b1;
          cnt_d    = '0;
          hcnt_d   = '0;
        end
      end

      ST_MEASURE: begin
        cnt_d  = cnt_inc;
        hcnt_d = level ? hcnt_inc : hcnt_q;
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          errp_new = period_bad;
          // s2 is high on the rise cycle, so both counters restart at 1.
          cnt_d    = CNT_ONE;
          hcnt_d   = CNT_ONE;
        end else if (timeout_hit) begin
          errt_new = 1'b1;
          cnt_d    = '0;
          hcnt_d   = '0;
          state_d  = ST_ARM;
        end
      end

      default: begin
        cnt_d   = '0;
        hcnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Disable overrides everything, including a coincident rise. The last
    // measurement stays visible on io_period/io_high.
    if (!io_en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      hcnt_d   = '0;
      period_d = period_q;
      high_d   = high_q;
      valid_d  = 1'b0;
      errp_new = 1'b0;
      errt_new = 1'b0;
    end

    // A new error in the same cycle as io_clear wins.
    errp_d = (errp_q & ~io_clear) | errp_new;
    errt_d = (errt_q & ~io_clear) | errt_new;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      errp_q   <= 1'b0;
      errt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      errp_q   <= errp_d;
      errt_q   <= errt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // ---------------------------------------------------------------------------
  assign io_period      = period_q;
  assign io_high        = high_q;
  assign io_valid       = valid_q;
  assign io_err_period  = errp_q;
  assign io_err_timeout = errt_q;
  assign io_state       = state_q;

endmodule

// File: tb/tb_clock_divider_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_monitor
//   Drives a synthetic divided clock into two monitors (TOL=1 and TOL=0) and
//   scores every io_valid against periods recorded by the stimulus generator.
// -----------------------------------------------------------------------------
module tb_clock_divider_monitor;

  localparam int TB_TOL = 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       en;
  logic       clear;
  logic [7:0] div;
  logic       clk_in;

  logic [15:0] period, high, period_t0, high_t0;
  logic        valid, errp, errt, valid_t0, errp_t0, errt_t0;
  logic [1:0]  state, state_t0;

  clock_divider_monitor #(
    .DIV_W(8), .CNT_W(16), .TOL(TB_TOL), .TIMEOUT(1024)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_en          (en),
    .io_clear       (clear),
    .io_div         (div),
    .io_clock_in    (clk_in),
    .io_period      (period),
    .io_high        (high),
    .io_valid       (valid),
    .io_err_period  (errp),
    .io_err_timeout (errt),
    .io_state       (state)
  );

  clock_divider_monitor #(
    .DIV_W(8), .CNT_W(16), .TOL(0), .TIMEOUT(1024)
  ) dut_t0 (
    .clock          (clock),
    .reset          (reset),
    .io_en          (en),
    .io_clear       (clear),
    .io_div         (div),
    .io_clock_in    (clk_in),
    .io_period      (period_t0),
    .io_high        (high_t0),
    .io_valid       (valid_t0),
    .io_err_period  (errp_t0),
    .io_err_timeout (errt_t0),
    .io_state       (state_t0)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_p_q[$];
  logic [15:0] exp_h_q[$];
  logic        exp_e_q[$];
  logic        exp_e0_q[$];

  logic err_m;   // expected sticky io_err_period, TOL=1 instance
  logic err0_m;  // expected sticky io_err_period, TOL=0 instance

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Record one completed period of the generated clock.
  task automatic push_exp(input int p, input int h);
    int  d;
    logic mism;
    logic mism0;
    d     = p - int'(div);
    mism  = (d > TB_TOL) || (d < -TB_TOL);
    mism0 = (d != 0);
    err_m  = (clear ? 1'b0 : err_m)  | mism;
    err0_m = (clear ? 1'b0 : err0_m) | mism0;
    exp_p_q.push_back(16'(p));
    exp_h_q.push_back(16'(h));
    exp_e_q.push_back(err_m);
    exp_e0_q.push_back(err0_m);
  endtask

  logic [15:0] mon_p, mon_h;
  logic        mon_e;

  always @(negedge clock) begin
    if (reset && valid) begin
      if (exp_p_q.size() == 0) begin
        check("valid_unexpected", {31'd0, valid}, 32'd0);
      end else begin
        mon_p = exp_p_q.pop_front();
        mon_h = exp_h_q.pop_front();
        mon_e = exp_e_q.pop_front();
        check("period", period, mon_p);
        check("high", high, mon_h);
        check("err_period", errp, mon_e);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && valid_t0) begin
      if (exp_e0_q.size() == 0)
        check("valid_unexpected_t0", {31'd0, valid_t0}, 32'd0);
      else
        check("err_period_t0", errp_t0, exp_e0_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // n periods, period in [pmin,pmax], high time in [hmin,hmax] (clamped to p-1).
  // The first rise of a run is the ARM edge and yields no measurement.
  task automatic gen(input int n, input int pmin, input int pmax, input int hmin, input int hmax);
    int p, h, pp, ph;
    bit first;
    first = 1'b1;
    pp = 0;
    ph = 0;
    @(negedge clock);
    for (int i = 0; i < n; i++) begin
      p = int'($urandom_range(pmax, pmin));
      h = int'($urandom_range(hmax, hmin));
      if (h > p - 1) h = p - 1;
      clk_in = 1'b1;
      if (!first) push_exp(pp, ph);
      first = 1'b0;
      pp = p;
      ph = h;
      repeat (h) @(negedge clock);
      clk_in = 1'b0;
      repeat (p - h) @(negedge clock);
    end
  endtask

  task automatic begin_run();
    en = 1'b0;
    repeat (2) @(negedge clock);
    en = 1'b1;
    @(negedge clock);
  endtask

  task automatic end_run();
    repeat (6) @(negedge clock);
    check("drain", exp_p_q.size(), 0);
    check("drain_t0", exp_e0_q.size(), 0);
    en = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear  = 1'b0;
    err_m  = 1'b0;
    err0_m = 1'b0;
    check("clear_err_period", errp, 0);
    check("clear_err_timeout", errt, 0);
    check("clear_err_period_t0", errp_t0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high"}, high, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_err_period"}, errp, 0);
    check({tag, "_err_timeout"}, errt, 0);
    check({tag, "_state"}, state, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int waited;
    reset  = 1'b0;
    en     = 1'b0;
    clear  = 1'b0;
    div    = 8'd2;
    clk_in = 1'b0;
    err_m  = 1'b0;
    err0_m = 1'b0;

    repeat (3) @(negedge clock);
    check_all_zero("reset");

    reset = 1'b1;
    @(negedge clock);
    check("idle_after_reset", state, 0);
    en = 1'b1;
    @(negedge clock);
    check("arm_after_en", state, 1);

    // Ideal /2
    gen(8, 2, 2, 1, 1);
    end_run();

    // Ideal /4, two fixed duty phases
    div = 8'd4;
    begin_run(); gen(6, 4, 4, 2, 2); end_run();
    begin_run(); gen(6, 4, 4, 3, 3); end_run();

    // Jittered /4: periods 3..5 stay within TOL=1
    begin_run(); gen(20, 3, 5, 1, 3); end_run();
    check("jitter_err_period", errp, 0);

    // io_div = 0: any period >= 2 mismatches
    div = 8'd0;
    begin_run(); gen(4, 2, 2, 1, 1); end_run();
    check("div0_err_period", errp, 1);
    do_clear();

    // Lost clock
    div = 8'd4;
    begin_run();
    gen(5, 4, 4, 2, 2);
    repeat (1000) @(negedge clock);
    check("timeout_not_early", errt, 0);
    waited = 0;
    while (!errt && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("timeout_set", errt, 1);
    check("timeout_state_arm", state, 1);
    // Restart: first rise re-arms, later ones measure
    gen(4, 4, 4, 2, 2);
    repeat (6) @(negedge clock);
    check("timeout_sticky", errt, 1);
    end_run();
    do_clear();

    // io_clear held across mismatching rises: error still wins
    clear = 1'b1;
    begin_run();
    gen(4, 7, 7, 3, 3);
    repeat (6) @(negedge clock);
    check("clear_held_after", errp, 0);
    check("drain_clear_held", exp_p_q.size(), 0);
    clear  = 1'b0;
    err_m  = 1'b0;
    err0_m = 1'b0;
    en     = 1'b0;
    @(negedge clock);

    // Reset asserted mid-period
    begin_run();
    gen(3, 4, 4, 2, 2);
    check("pre_reset_period", period, 4);
    clk_in = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    clk_in = 1'b0;
    exp_p_q.delete();
    exp_h_q.delete();
    exp_e_q.delete();
    exp_e0_q.delete();
    err_m  = 1'b0;
    err0_m = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("held_reset");
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_arm", state, 1);
    gen(4, 4, 4, 2, 2);
    end_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Time bound for the whole run
  initial begin
    #1ms;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: time limit reached before the sequence completed");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
